// File: rtl/e_mdu.sv
// e_mdu: multi-cycle multiply/divide unit holding architectural HI/LO.
// Define MDU_MADD_EN to enable madd/maddu/msub/msubu accumulate ops.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [3:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    typedef enum logic {IDLE, RUN} state_t;
    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [63:0]   shadow, shadow_nx, res;
    logic [31:0]   hi_nx, lo_nx;
    logic [63:0]   sprod, uprod;
    logic signed [31:0] sq, sr;
    logic          is_mul, is_div, is_run, ovf;
    // Low 64 bits of the product of sign-extended operands equal the signed product
    assign sprod = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign uprod = {32'b0, A} * {32'b0, B};
    assign sq    = $signed(A) / $signed(B);
    assign sr    = $signed(A) % $signed(B);
    assign ovf   = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    assign is_div = (MDOp == 4'd3) || (MDOp == 4'd4);
`ifdef MDU_MADD_EN
    logic [63:0] acc;
    assign acc    = {HI, LO};
    assign is_mul = (MDOp == 4'd1) || (MDOp == 4'd2) || (MDOp >= 4'd7 && MDOp <= 4'd10);
    always_comb begin
        res = (MDOp == 4'd1) ? sprod : uprod;
        if (is_div)
            res = (B == 32'd0) ? {A, 32'hFFFF_FFFF} :
                  (MDOp == 4'd3 && ovf) ? {32'd0, 32'h8000_0000} :
                  (MDOp == 4'd3) ? {sr, sq} : {A % B, A / B};
        else if (MDOp == 4'd7)  res = acc + sprod;
        else if (MDOp == 4'd8)  res = acc + uprod;
        else if (MDOp == 4'd9)  res = acc - sprod;
        else if (MDOp == 4'd10) res = acc - uprod;
    end
`else
    assign is_mul = (MDOp == 4'd1) || (MDOp == 4'd2);
    always_comb begin
        res = (MDOp == 4'd1) ? sprod : uprod;
        if (is_div)
            res = (B == 32'd0) ? {A, 32'hFFFF_FFFF} :
                  (MDOp == 4'd3 && ovf) ? {32'd0, 32'h8000_0000} :
                  (MDOp == 4'd3) ? {sr, sq} : {A % B, A / B};
    end
`endif
    assign is_run = Start && (is_mul || is_div);
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        shadow_nx = shadow;
        hi_nx     = HI;
        lo_nx     = LO;
        if (state == IDLE) begin
            if (is_run) begin
                shadow_nx = res;
                cnt_nx    = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                state_nx  = RUN;
            end else if (Start && MDOp == 4'd5) begin
                hi_nx = A;
            end else if (Start && MDOp == 4'd6) begin
                lo_nx = A;
            end
        end else begin
            cnt_nx = cnt - CW'(1);
            if (cnt == CW'(1)) begin
                {hi_nx, lo_nx} = shadow;
                state_nx       = IDLE;
            end
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            shadow <= '0;
            HI     <= '0;
            LO     <= '0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            shadow <= shadow_nx;
            HI     <= hi_nx;
            LO     <= lo_nx;
        end
    end
    assign Busy = (state == RUN);
endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: scoreboard bench for e_mdu; expected {HI,LO} queued at issue, checked at completion.
module tb_e_mdu;
    logic        clk = 0, reset = 0, Start = 0;
    logic [3:0]  MDOp = 0;
    logic [31:0] A = 0, B = 0;
    logic        Busy;
    logic [31:0] HI, LO;
    logic [63:0] sb[$];
    int          vectors = 0, miscompares = 0;

    e_mdu dut (.clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp), .A(A), .B(B),
               .Busy(Busy), .HI(HI), .LO(LO));

    always #5 clk = ~clk;

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        Start = 1; MDOp = op; A = a; B = b;
        @(negedge clk);
        Start = 0; MDOp = 0;
    endtask

    task automatic wait_idle(output int busy);
        busy = 0;
        while (Busy && busy < 100) begin
            busy++;
            @(negedge clk);
        end
    endtask

    task automatic check_done(input string name, input int busy, input int n);
        logic [63:0] exp;
        vectors++;
        if (busy !== n) begin
            miscompares++;
            $display("FAIL %s busy_cycles got %0d want %0d", name, busy, n);
        end
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL %s scoreboard empty", name);
        end else begin
            exp = sb.pop_front();
            if ({HI, LO} !== exp) begin
                miscompares++;
                $display("FAIL %s hilo got %h want %h", name, {HI, LO}, exp);
            end
        end
    endtask

    task automatic test_reset;
        #3;
        vectors++;
        if ({Busy, HI, LO} !== 65'd0) begin
            miscompares++;
            $display("FAIL reset got busy=%b hi=%h lo=%h want 0", Busy, HI, LO);
        end
        @(negedge clk); reset = 1;
    endtask

    task automatic test_mult;
        int busy;
        logic [31:0] a, b;
        sb.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFE});
        issue(4'd1, 32'hFFFF_FFFF, 32'd2); wait_idle(busy); check_done("mult", busy, 5);
        sb.push_back({32'h0000_0001, 32'hFFFF_FFFE});
        issue(4'd2, 32'hFFFF_FFFF, 32'd2); wait_idle(busy); check_done("multu", busy, 5);
        for (int i = 0; i < 3; i++) begin
            a = $urandom; b = $urandom;
            sb.push_back({{32{a[31]}}, a} * {{32{b[31]}}, b});
            issue(4'd1, a, b); wait_idle(busy); check_done("mult_rand", busy, 5);
            sb.push_back({32'd0, a} * {32'd0, b});
            issue(4'd2, a, b); wait_idle(busy); check_done("multu_rand", busy, 5);
        end
    endtask

    task automatic test_div;
        int busy;
        sb.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
        issue(4'd3, 32'hFFFF_FFF9, 32'd2); wait_idle(busy); check_done("div_neg", busy, 10);
        sb.push_back({32'h0000_0000, 32'h8000_0000});
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle(busy); check_done("div_ovf", busy, 10);
        sb.push_back({32'h1234_5678, 32'hFFFF_FFFF});
        issue(4'd4, 32'h1234_5678, 32'd0); wait_idle(busy); check_done("divu_zero", busy, 10);
        sb.push_back({32'h0000_0005, 32'hFFFF_FFFF});
        issue(4'd3, 32'd5, 32'd0); wait_idle(busy); check_done("div_zero", busy, 10);
        sb.push_back({32'd1, 32'd33});
        issue(4'd4, 32'd100, 32'd3); wait_idle(busy); check_done("divu", busy, 10);
    endtask

    task automatic test_back_to_back;
        int busy;
        logic [63:0] old;
        old = {HI, LO};
        sb.push_back({32'd2, 32'd14});
        issue(4'd3, 32'd100, 32'd7);
        @(negedge clk);
        Start = 1; MDOp = 4'd1; A = 32'd3; B = 32'd3;
        @(negedge clk);
        Start = 0; MDOp = 0;
        vectors++;
        if ({HI, LO} !== old) begin
            miscompares++;
            $display("FAIL run_hold got %h want %h", {HI, LO}, old);
        end
        wait_idle(busy); check_done("div_ignore_start", busy, 8);
        vectors++;
        if (Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL no_late_run got busy=%b want 0", Busy);
        end
        sb.push_back({32'hA5A5_A5A5, 32'd14});
        issue(4'd5, 32'hA5A5_A5A5, 32'd0); wait_idle(busy); check_done("mthi", busy, 0);
        sb.push_back({32'hA5A5_A5A5, 32'h5A5A_0001});
        issue(4'd6, 32'h5A5A_0001, 32'd0); wait_idle(busy); check_done("mtlo", busy, 0);
        sb.push_back({32'hA5A5_A5A5, 32'h5A5A_0001});
        issue(4'd15, 32'd9, 32'd9); wait_idle(busy); check_done("undef_op", busy, 0);
        sb.push_back({32'hA5A5_A5A5, 32'h5A5A_0001});
        issue(4'd0, 32'd9, 32'd9); wait_idle(busy); check_done("none_op", busy, 0);
    endtask

    task automatic test_async_reset;
        issue(4'd1, 32'd3, 32'd3);
        @(negedge clk);
        #2 reset = 0;
        #1;
        vectors++;
        if ({Busy, HI, LO} !== 65'd0) begin
            miscompares++;
            $display("FAIL async_reset got busy=%b hi=%h lo=%h want 0", Busy, HI, LO);
        end
        @(negedge clk); reset = 1;
        repeat (8) @(negedge clk);
        vectors++;
        if ({Busy, HI, LO} !== 65'd0) begin
            miscompares++;
            $display("FAIL late_commit got busy=%b hi=%h lo=%h want 0", Busy, HI, LO);
        end
    endtask

    task automatic test_madd;
        int busy;
        sb.push_back({32'd0, 32'd0});
        issue(4'd5, 32'd0, 32'd0); wait_idle(busy); check_done("mthi0", busy, 0);
        sb.push_back({32'd0, 32'd5});
        issue(4'd6, 32'd5, 32'd0); wait_idle(busy); check_done("mtlo5", busy, 0);
`ifdef MDU_MADD_EN
        sb.push_back({32'd0, 32'd17});
        issue(4'd7, 32'd3, 32'd4); wait_idle(busy); check_done("madd", busy, 5);
        sb.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
        issue(4'd9, 32'd1, 32'd20); wait_idle(busy); check_done("msub", busy, 5);
`else
        sb.push_back({32'd0, 32'd5});
        issue(4'd7, 32'd3, 32'd4); wait_idle(busy); check_done("madd_off", busy, 0);
        sb.push_back({32'd0, 32'd5});
        issue(4'd10, 32'd1, 32'd20); wait_idle(busy); check_done("msubu_off", busy, 0);
`endif
    endtask

    initial begin
        test_reset;
        test_mult;
        test_div;
        test_back_to_back;
        test_async_reset;
        test_madd;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
